// File: rtl/decoder2to4_top.sv
// 2-to-4 one-hot decoder built three ways (behavioural, structural, dataflow),
// each with its own registered output group, plus a registered disagreement flag.

module decoder2to4_bh (
  input  logic       Sel0,
  input  logic       Sel1,
  output logic [3:0] y_o
);
  always_comb begin
    y_o = 4'b0000;
    case ({Sel1, Sel0})
      2'd0:    y_o = 4'b0001;
      2'd1:    y_o = 4'b0010;
      2'd2:    y_o = 4'b0100;
      2'd3:    y_o = 4'b1000;
      default: y_o = 4'b0000;
    endcase
  end
endmodule

module decoder2to4_st (
  input  logic       Sel0,
  input  logic       Sel1,
  output logic [3:0] y_o
);
  logic sel0_n, sel1_n;
  logic y0, y1, y2, y3;

  not u_inv0 (sel0_n, Sel0);
  not u_inv1 (sel1_n, Sel1);

  and u_and0 (y0, sel1_n, sel0_n);
  and u_and1 (y1, sel1_n, Sel0);
  and u_and2 (y2, Sel1,   sel0_n);
  and u_and3 (y3, Sel1,   Sel0);

  assign y_o = {y3, y2, y1, y0};
endmodule

module decoder2to4_df (
  input  logic       Sel0,
  input  logic       Sel1,
  output logic [3:0] y_o
);
  logic sel0_n, sel1_n;

  assign sel0_n = ~Sel0;
  assign sel1_n = ~Sel1;
  assign y_o[0] = sel1_n & sel0_n;
  assign y_o[1] = sel1_n & Sel0;
  assign y_o[2] = Sel1   & sel0_n;
  assign y_o[3] = Sel1   & Sel0;
endmodule

module decoder2to4_top (
  input  logic clk,
  input  logic rst,
  input  logic Sel0,
  input  logic Sel1,
  output logic bh_Y0,
  output logic bh_Y1,
  output logic bh_Y2,
  output logic bh_Y3,
  output logic st_Y0,
  output logic st_Y1,
  output logic st_Y2,
  output logic st_Y3,
  output logic df_Y0,
  output logic df_Y1,
  output logic df_Y2,
  output logic df_Y3,
  output logic mismatch
);
  logic [3:0] bh_d, st_d, df_d;
  logic [3:0] bh_q, st_q, df_q;
  logic       mismatch_d, mismatch_q;

  decoder2to4_bh u_bh (.Sel0(Sel0), .Sel1(Sel1), .y_o(bh_d));
  decoder2to4_st u_st (.Sel0(Sel0), .Sel1(Sel1), .y_o(st_d));
  decoder2to4_df u_df (.Sel0(Sel0), .Sel1(Sel1), .y_o(df_d));

  // Compared before the registers so the flag lines up with the outputs it describes.
  assign mismatch_d = (bh_d != st_d) || (bh_d != df_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      bh_q       <= 4'b0000;
      st_q       <= 4'b0000;
      df_q       <= 4'b0000;
      mismatch_q <= 1'b0;
    end else begin
      bh_q       <= bh_d;
      st_q       <= st_d;
      df_q       <= df_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign {bh_Y3, bh_Y2, bh_Y1, bh_Y0} = bh_q;
  assign {st_Y3, st_Y2, st_Y1, st_Y0} = st_q;
  assign {df_Y3, df_Y2, df_Y1, df_Y0} = df_q;
  assign mismatch = mismatch_q;
endmodule

// File: tb/tb_decoder2to4_top.sv
// Directed bench for decoder2to4_top: reset, per-code decode, latency, mid-run reset, random sweep.

module tb_decoder2to4_top;
  logic clk = 1'b0;
  logic rst, Sel0, Sel1;
  logic bh_Y0, bh_Y1, bh_Y2, bh_Y3;
  logic st_Y0, st_Y1, st_Y2, st_Y3;
  logic df_Y0, df_Y1, df_Y2, df_Y3;
  logic mismatch;

  int n_chk = 0;
  int n_err = 0;

  decoder2to4_top dut (
    .clk(clk), .rst(rst), .Sel0(Sel0), .Sel1(Sel1),
    .bh_Y0(bh_Y0), .bh_Y1(bh_Y1), .bh_Y2(bh_Y2), .bh_Y3(bh_Y3),
    .st_Y0(st_Y0), .st_Y1(st_Y1), .st_Y2(st_Y2), .st_Y3(st_Y3),
    .df_Y0(df_Y0), .df_Y1(df_Y1), .df_Y2(df_Y2), .df_Y3(df_Y3),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks all three groups against one Y3..Y0 pattern and the flag against 0.
  task automatic chk_all(input string tag, input logic [3:0] exp);
    chk({tag, " bh"}, {12'h0, bh_Y3, bh_Y2, bh_Y1, bh_Y0}, {12'h0, exp});
    chk({tag, " st"}, {12'h0, st_Y3, st_Y2, st_Y1, st_Y0}, {12'h0, exp});
    chk({tag, " df"}, {12'h0, df_Y3, df_Y2, df_Y1, df_Y0}, {12'h0, exp});
    chk({tag, " mm"}, {15'h0, mismatch}, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    {Sel1, Sel0} = s;
  endtask

  logic [3:0] exp_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    logic [1:0] s;
    rst = 1'b1;
    set_sel(2'd3);
    tick();
    chk_all("rst c1", 4'b0000);
    tick();
    chk_all("rst c2", 4'b0000);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_sel(i[1:0]);
      tick();
      chk_all($sformatf("dec S=%0d", i), exp_tbl[i]);
    end

    // Latency: S=1 registered, then S=2 applied but not yet clocked
    set_sel(2'd1);
    tick();
    chk_all("lat pre", 4'b0010);
    set_sel(2'd2);
    #2;
    chk_all("lat same", 4'b0010);
    tick();
    chk_all("lat next", 4'b0100);

    rst = 1'b1;
    tick();
    chk_all("midrst", 4'b0000);
    rst = 1'b0;
    tick();
    chk_all("post rst", 4'b0100);

    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(0, 3));
      set_sel(s);
      tick();
      chk_all($sformatf("rnd %0d S=%0d", i, s), exp_tbl[s]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
